// File: rtl/clk_rst_tick_gen.sv
// Reset sequencer plus NUM_CH programmable tick/square-wave channels.
// Ticks are single-cycle clock enables, so nothing downstream is clocked by a divided net.
module clk_rst_tick_gen #(
  parameter int          RST_HOLD_CYCLES = 31,
  parameter int          NUM_CH          = 4,
  parameter int          DIV_W           = 24,
  parameter int unsigned DEFAULT_DIV     = 1048575
) (
  input  logic              CLK12MHZ,
  input  logic              resetn,
  input  logic              ext_rst_req,
  input  logic              div_we,
  input  logic [2:0]        div_sel,
  input  logic [DIV_W-1:0]  div_value,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              sys_resetn,
  output logic              rst_done,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave
);

  localparam int              HCW       = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(RST_HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
  logic           rst_done_nxt;
  logic           sync_q1, sync_n;

  logic [DIV_W-1:0]  cnt   [NUM_CH];
  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic              ch_active;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] term;

  // Release of resetn is synchronised; assertion stays fully asynchronous.
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= 1'b0;
      sync_n  <= 1'b0;
    end else begin
      sync_q1 <= 1'b1;
      sync_n  <= sync_q1;
    end
  end

  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      state    <= HOLD;
      hold_cnt <= '0;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      rst_done <= rst_done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    rst_done_nxt = 1'b0;
    case (state)
      HOLD: begin
        if (ext_rst_req) begin
          hold_cnt_nxt = '0;
        end else if (sync_n) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt    = RUN;
            hold_cnt_nxt = '0;
            rst_done_nxt = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + HCW'(1);
          end
        end
      end
      RUN: begin
        if (ext_rst_req) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = HOLD;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  assign sys_resetn = (state == RUN);

  // Channels run only on edges after which sys_resetn is still high.
  assign ch_active = (state == RUN) && !ext_rst_req;

  always_comb begin
    wr_hit = '0;
    term   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = div_we && ch_active && (div_sel == 3'(i));
      term[i]   = (cnt[i] == div_q[i]);
    end
  end

  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]   <= '0;
        div_q[i] <= DIV_RST;
      end
      tick <= '0;
      wave <= '0;
    end else if (!ch_active) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
      tick <= '0;
      wave <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          div_q[i] <= div_value;
          cnt[i]   <= '0;
          tick[i]  <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b0;
        end else if (term[i]) begin
          cnt[i]  <= '0;
          tick[i] <= 1'b1;
          wave[i] <= ~wave[i];
        end else begin
          cnt[i]  <= cnt[i] + DIV_W'(1);
          tick[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_rst_tick_gen.sv
// Bench for clk_rst_tick_gen: directed reset/tick scenarios then random traffic,
// every cycle compared against an edge-counting reference model.
module tb_clk_rst_tick_gen;

  localparam int H    = 5;
  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int DDEF = 6;

  logic            CLK12MHZ = 1'b0;
  logic            resetn;
  logic            ext_rst_req;
  logic            div_we;
  logic [2:0]      div_sel;
  logic [DW-1:0]   div_value;
  logic [NCH-1:0]  ch_en;
  logic            sys_resetn;
  logic            rst_done;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  wave;

  int tests = 0;
  int fails = 0;
  int first;
  int n;

  // Model: reset progress as edge counts, each channel as a count of enabled edges since restart.
  bit             m_run;
  int             m_sync;
  int             m_hold;
  bit             exp_done;
  int             m_div   [NCH];
  longint         m_phase [NCH];
  logic [NCH-1:0] exp_tick;
  logic [NCH-1:0] exp_wave;

  clk_rst_tick_gen #(
    .RST_HOLD_CYCLES(H),
    .NUM_CH(NCH),
    .DIV_W(DW),
    .DEFAULT_DIV(DDEF)
  ) dut (
    .CLK12MHZ(CLK12MHZ),
    .resetn(resetn),
    .ext_rst_req(ext_rst_req),
    .div_we(div_we),
    .div_sel(div_sel),
    .div_value(div_value),
    .ch_en(ch_en),
    .sys_resetn(sys_resetn),
    .rst_done(rst_done),
    .tick(tick),
    .wave(wave)
  );

  always #5 CLK12MHZ = ~CLK12MHZ;

  task automatic modelReset();
    m_run    = 1'b0;
    m_sync   = 0;
    m_hold   = 0;
    exp_done = 1'b0;
    exp_tick = '0;
    exp_wave = '0;
    for (int i = 0; i < NCH; i++) begin
      m_div[i]   = DDEF;
      m_phase[i] = 0;
    end
  endtask

  task automatic modelEdge();
    bit active;
    active   = m_run && !ext_rst_req;
    exp_done = 1'b0;
    if (m_run) begin
      if (ext_rst_req) begin
        m_run  = 1'b0;
        m_hold = 0;
      end
    end else if (m_sync < 2) begin
      m_sync++;
    end else if (ext_rst_req) begin
      m_hold = 0;
    end else begin
      m_hold++;
      if (m_hold == H) begin
        m_run    = 1'b1;
        m_hold   = 0;
        exp_done = 1'b1;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!active) begin
        m_phase[i]  = 0;
        exp_tick[i] = 1'b0;
        exp_wave[i] = 1'b0;
      end else if (div_we && (int'(div_sel) == i)) begin
        m_div[i]    = int'(div_value);
        m_phase[i]  = 0;
        exp_tick[i] = 1'b0;
      end else if (!ch_en[i]) begin
        m_phase[i]  = 0;
        exp_tick[i] = 1'b0;
      end else begin
        m_phase[i]++;
        exp_tick[i] = (m_phase[i] % longint'(m_div[i] + 1) == 0);
        if (exp_tick[i]) exp_wave[i] = ~exp_wave[i];
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("sys_resetn", 32'(sys_resetn), 32'(m_run));
    checkValue("rst_done", 32'(rst_done), 32'(exp_done));
    checkValue("tick", 32'(tick), 32'(exp_tick));
    checkValue("wave", 32'(wave), 32'(exp_wave));
  endtask

  task automatic applyStimulus(input bit ext, input bit we, input logic [2:0] sel,
                               input logic [DW-1:0] val, input logic [NCH-1:0] en);
    ext_rst_req = ext;
    div_we      = we;
    div_sel     = sel;
    div_value   = val;
    ch_en       = en;
    modelEdge();
    @(posedge CLK12MHZ);
    #1;
    checkOutput();
  endtask

  initial begin
    resetn      = 1'b0;
    ext_rst_req = 1'b0;
    div_we      = 1'b0;
    div_sel     = '0;
    div_value   = '0;
    ch_en       = '0;
    modelReset();
    repeat (2) begin
      @(posedge CLK12MHZ);
      #1;
      checkOutput();
    end

    // T1: power-on release, sys_resetn after 2+H edges, one rst_done pulse
    resetn = 1'b1;
    first  = 0;
    n      = 0;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, '0);
      if (sys_resetn && first == 0) first = e;
      if (rst_done) n++;
    end
    checkValue("T1 release edge", 32'(first), 32'(2 + H));
    checkValue("T1 rst_done width", 32'(n), 32'd1);

    // T2: div[0]=3 ticks on enabled edges 4, 8, 12
    applyStimulus(1'b0, 1'b1, 3'd0, DW'(3), '0);
    first = 0;
    n     = 0;
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0001);
      if (tick[0]) begin
        n++;
        if (first == 0) first = e;
      end
    end
    checkValue("T2 first tick", 32'(first), 32'd4);
    checkValue("T2 tick count", 32'(n), 32'd3);

    // T3: div[1]=0 ticks every cycle, disable freezes wave
    applyStimulus(1'b0, 1'b1, 3'd1, DW'(0), 4'b0001);
    n = 0;
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0011);
      if (tick[1]) n++;
    end
    checkValue("T3 tick every cycle", 32'(n), 32'd6);
    for (int e = 1; e <= 4; e++) applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0001);

    // T4: rewrite div[2] mid-period, then an out-of-range select
    applyStimulus(1'b0, 1'b1, 3'd2, DW'(15), 4'b0101);
    for (int e = 1; e <= 5; e++) applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0101);
    applyStimulus(1'b0, 1'b1, 3'd2, DW'(9), 4'b0101);
    first = 0;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0101);
      if (tick[2] && first == 0) first = e;
    end
    checkValue("T4 period after write", 32'(first), 32'd10);
    applyStimulus(1'b0, 1'b1, 3'd5, DW'(1), 4'b0101);
    for (int e = 1; e <= 12; e++) applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0101);

    // T5: external reset request, divides retained afterwards
    applyStimulus(1'b1, 1'b0, 3'd0, '0, 4'b0111);
    n = 0;
    for (int e = 1; e <= H + 20; e++) begin
      if (!sys_resetn) n++;
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b0111);
    end
    checkValue("T5 hold length", 32'(n), 32'(H));

    // All-ones divide gives a 2^DW period
    applyStimulus(1'b0, 1'b1, 3'd3, '1, 4'b0000);
    first = 0;
    n     = 0;
    for (int e = 1; e <= 260; e++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b1000);
      if (tick[3]) begin
        n++;
        if (first == 0) first = e;
      end
    end
    checkValue("all-ones first tick", 32'(first), 32'd256);
    checkValue("all-ones tick count", 32'(n), 32'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      logic [DW-1:0] v;
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 9) == 0) ? DW'(255) : DW'($urandom_range(0, 12));
      applyStimulus(r < 2, (r >= 2) && (r < 20), 3'($urandom_range(0, 7)), v,
                    NCH'($urandom_range(0, 15)));
    end

    // T6: asynchronous reset between edges, then full re-sequence with default divides
    for (int e = 1; e <= 4; e++) applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b1111);
    #3;
    resetn = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(posedge CLK12MHZ);
    #1;
    checkOutput();
    resetn = 1'b1;
    first  = 0;
    for (int e = 1; e <= 20; e++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, '0, 4'b1111);
      if (tick[0] && first == 0) first = e;
    end
    checkValue("T6 default div tick", 32'(first), 32'(2 + H + DDEF + 1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
